// File: rtl/nocif_dram_write_eg_bresp_pkg.sv
// Shared types and constants for the DRAM write-response egress.
// Optional bresp error tracking is enabled by defining NVDLA_NOCIF_BRESP_ERR_EN.
package nocif_dram_write_eg_bresp_pkg;

   localparam int unsigned CQ_PD_W    = 3;
   localparam int unsigned CQ_ACK_BIT = 2;
   localparam int unsigned CQ_LEN_LSB = 0;
   localparam int unsigned LEN_W      = 2;
   localparam int unsigned AXI_ID_W   = 8;
   localparam int unsigned THREAD_W   = 4;
   localparam int unsigned BRESP_W    = 2;
   localparam int unsigned SKID_DEPTH = 2;
   localparam logic [BRESP_W-1:0] BRESP_OKAY = 2'b00;

`ifdef NVDLA_NOCIF_BRESP_ERR_EN
   localparam int unsigned SKID_W = THREAD_W + BRESP_W;
`else
   localparam int unsigned SKID_W = THREAD_W;
`endif

   typedef struct packed {
      logic             require_ack;
      logic [LEN_W-1:0] len;
   } cq_entry_t;

   // Split a raw context-queue head word into its fields.
   function automatic cq_entry_t cq_entry_unpack(input logic [CQ_PD_W-1:0] pd);
      cq_entry_t e;
      e.require_ack = pd[CQ_ACK_BIT];
      e.len         = pd[CQ_LEN_LSB +: LEN_W];
      return e;
   endfunction

endpackage

// File: rtl/nocif_dram_write_eg_skid.sv
// Two-entry input buffer with a registered ready; head is always slot 0.
module nocif_dram_write_eg_skid
   import nocif_dram_write_eg_bresp_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic [WIDTH-1:0] in_pd,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [WIDTH-1:0] out_pd
);

   logic             vld1;
   logic [WIDTH-1:0] pd1;
   logic             vld0_n, vld1_n, rdy_n;
   logic [WIDTH-1:0] pd0_n, pd1_n;
   logic             push, pop;
   logic [1:0]       occ_n;

   // Slot update: pops shift slot 1 forward, pushes fill the first free slot.
   always_comb begin
      push   = in_vld & in_rdy;
      pop    = out_vld & out_rdy;
      vld0_n = out_vld;
      vld1_n = vld1;
      pd0_n  = out_pd;
      pd1_n  = pd1;
      case ({push, pop})
         2'b01: begin
            vld0_n = vld1;
            pd0_n  = pd1;
            vld1_n = 1'b0;
         end
         2'b10: begin
            if (!out_vld) begin
               vld0_n = 1'b1;
               pd0_n  = in_pd;
            end else begin
               vld1_n = 1'b1;
               pd1_n  = in_pd;
            end
         end
         2'b11: begin
            if (vld1) begin
               pd0_n = pd1;
               pd1_n = in_pd;
            end else begin
               pd0_n = in_pd;
            end
         end
         default: ;
      endcase
      occ_n = {1'b0, vld0_n} + {1'b0, vld1_n};
      rdy_n = 32'(occ_n) < SKID_DEPTH;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_vld <= 1'b0;
         vld1    <= 1'b0;
         out_pd  <= '0;
         pd1     <= '0;
         in_rdy  <= 1'b0;
      end else begin
         out_vld <= vld0_n;
         vld1    <= vld1_n;
         out_pd  <= pd0_n;
         pd1     <= pd1_n;
         in_rdy  <= rdy_n;
      end
   end

endmodule

// File: rtl/nocif_dram_write_eg_bresp.sv
// DRAM write-response egress: retires AXI B responses against per-thread context.
// Define NVDLA_NOCIF_BRESP_ERR_EN to add sticky bresp error reporting.
module nocif_dram_write_eg_bresp
   import nocif_dram_write_eg_bresp_pkg::*;
#(
   parameter int unsigned NUM_CLIENTS = 5
) (
   input  logic                         nvdla_core_clk,
   input  logic                         nvdla_core_rstn,
   input  logic                         noc2mcif_axi_b_bvalid,
   output logic                         noc2mcif_axi_b_bready,
   input  logic [AXI_ID_W-1:0]          noc2mcif_axi_b_bid,
   input  logic [BRESP_W-1:0]           noc2mcif_axi_b_bresp,
   input  logic [NUM_CLIENTS-1:0]       cq_rd_pvld,
   output logic [NUM_CLIENTS-1:0]       cq_rd_prdy,
   input  logic [CQ_PD_W*NUM_CLIENTS-1:0] cq_rd_pd,
   output logic [NUM_CLIENTS-1:0]       mcif2client_wr_rsp_complete,
   output logic                         eg2ig_axi_vld,
   output logic [LEN_W-1:0]             eg2ig_axi_len,
`ifdef NVDLA_NOCIF_BRESP_ERR_EN
   output logic                         bresp_err,
   output logic [THREAD_W-1:0]          bresp_err_thread,
`endif
   output logic                         unknown_id_err
);

   logic                   head_vld;
   logic [SKID_W-1:0]      head_pd;
   logic [SKID_W-1:0]      skid_in;
   logic [THREAD_W-1:0]    head_thread;
   logic                   known_c;
   logic                   pop_c;
   logic [NUM_CLIENTS-1:0] prdy_c;
   logic [NUM_CLIENTS-1:0] complete_c;
   cq_entry_t              sel_c;

`ifdef NVDLA_NOCIF_BRESP_ERR_EN
   logic [BRESP_W-1:0]     head_bresp;
   logic                   unused_bits;
   assign skid_in     = {noc2mcif_axi_b_bid[THREAD_W-1:0], noc2mcif_axi_b_bresp};
   assign head_bresp  = head_pd[BRESP_W-1:0];
   assign unused_bits = ^noc2mcif_axi_b_bid[AXI_ID_W-1:THREAD_W];
`else
   logic                   unused_bits;
   assign skid_in     = noc2mcif_axi_b_bid[THREAD_W-1:0];
   assign unused_bits = ^{noc2mcif_axi_b_bid[AXI_ID_W-1:THREAD_W], noc2mcif_axi_b_bresp};
`endif
   assign head_thread = head_pd[SKID_W-1 -: THREAD_W];

   nocif_dram_write_eg_skid #(.WIDTH(SKID_W)) u_skid (
      .clk     (nvdla_core_clk),
      .rst_n   (nvdla_core_rstn),
      .in_vld  (noc2mcif_axi_b_bvalid),
      .in_rdy  (noc2mcif_axi_b_bready),
      .in_pd   (skid_in),
      .out_vld (head_vld),
      .out_rdy (pop_c),
      .out_pd  (head_pd)
   );

   // Route the head to its thread's context queue; unknown threads drop immediately.
   always_comb begin
      prdy_c  = '0;
      sel_c   = '0;
      known_c = 32'(head_thread) < NUM_CLIENTS;
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
         if (head_thread == THREAD_W'(i)) begin
            prdy_c[i] = head_vld & cq_rd_pvld[i];
            sel_c     = cq_entry_unpack(cq_rd_pd[i*CQ_PD_W +: CQ_PD_W]);
         end
      end
      pop_c      = known_c ? (|prdy_c) : head_vld;
      complete_c = sel_c.require_ack ? prdy_c : '0;
   end

   assign cq_rd_prdy = prdy_c;

   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) begin
         eg2ig_axi_vld               <= 1'b0;
         eg2ig_axi_len               <= '0;
         mcif2client_wr_rsp_complete <= '0;
         unknown_id_err              <= 1'b0;
      end else begin
         eg2ig_axi_vld               <= pop_c & known_c;
         eg2ig_axi_len               <= (pop_c & known_c) ? sel_c.len : '0;
         mcif2client_wr_rsp_complete <= complete_c;
         unknown_id_err              <= unknown_id_err | (head_vld & ~known_c);
      end
   end

`ifdef NVDLA_NOCIF_BRESP_ERR_EN
   logic bresp_hit_c;
   assign bresp_hit_c = pop_c & known_c & (head_bresp != BRESP_OKAY);

   // First failing thread is latched; later errors only keep the flag set.
   always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rstn) begin
         bresp_err        <= 1'b0;
         bresp_err_thread <= '0;
      end else begin
         bresp_err <= bresp_err | bresp_hit_c;
         if (bresp_hit_c && !bresp_err) begin
            bresp_err_thread <= head_thread;
         end
      end
   end
`endif

endmodule

// File: tb/tb_nocif_dram_write_eg_bresp.sv
// Scoreboard bench for nocif_dram_write_eg_bresp: in-order B retirement model with per-thread cq queues.
module tb_nocif_dram_write_eg_bresp;

   localparam int NC = 5;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic           bvalid = 1'b0;
   logic           bready;
   logic [7:0]     bid = 8'h00;
   logic [1:0]     bresp = 2'b00;
   logic [NC-1:0]  pvld = '0;
   logic [NC-1:0]  prdy;
   logic [3*NC-1:0] pd = '0;
   logic [NC-1:0]  complete;
   logic           vld;
   logic [1:0]     len;
   logic           err;
`ifdef NVDLA_NOCIF_BRESP_ERR_EN
   logic           berr;
   logic [3:0]     bthr;
`endif

   nocif_dram_write_eg_bresp #(.NUM_CLIENTS(NC)) dut (
      .nvdla_core_clk              (clk),
      .nvdla_core_rstn             (rstn),
      .noc2mcif_axi_b_bvalid       (bvalid),
      .noc2mcif_axi_b_bready       (bready),
      .noc2mcif_axi_b_bid          (bid),
      .noc2mcif_axi_b_bresp        (bresp),
      .cq_rd_pvld                  (pvld),
      .cq_rd_prdy                  (prdy),
      .cq_rd_pd                    (pd),
      .mcif2client_wr_rsp_complete (complete),
      .eg2ig_axi_vld               (vld),
      .eg2ig_axi_len               (len),
`ifdef NVDLA_NOCIF_BRESP_ERR_EN
      .bresp_err                   (berr),
      .bresp_err_thread            (bthr),
`endif
      .unknown_id_err              (err)
   );

   int         n_cmp = 0;
   int         n_bad = 0;
   int         sbq[$];             // threads of accepted valid-thread B responses, in order
   logic [2:0] plan[NC][$];        // every cq entry ever produced, per thread
   int         ret_idx[NC];
   int         debt[$];            // produced but not yet visible cq entries
   logic [2:0] cq_live[NC][$];     // entries currently visible to the DUT
   logic       fast = 1'b1;
   logic [NC-1:0] pop_mask = '0;
   logic       exp_err = 1'b0;
   logic       exp_berr = 1'b0;
   logic [3:0] exp_bthr = 4'd0;
   bit         abort = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add_cq(input int t, input logic [2:0] p);
      plan[t].push_back(p);
      debt.push_back(t * 8 + int'(p));
   endtask

   // Context-queue producer: pops what the DUT took, releases new entries, drives heads.
   always @(negedge clk) begin
      for (int i = 0; i < NC; i++)
         if (pop_mask[i] && cq_live[i].size() != 0) void'(cq_live[i].pop_front());
      while (debt.size() != 0 && (fast || $urandom_range(0, 2) == 0)) begin
         int d;
         d = debt.pop_front();
         cq_live[d / 8].push_back(3'(d % 8));
         if (!fast) break;
      end
      for (int i = 0; i < NC; i++) begin
         pvld[i]       = cq_live[i].size() != 0;
         pd[3*i +: 3]  = (cq_live[i].size() != 0) ? cq_live[i][0] : 3'b000;
      end
      #1;
      pop_mask = prdy;
   end

   // Monitor: every credit return must match the next retiring response.
   always @(negedge clk) begin
      if (rstn) begin
         if (vld) begin
            if (sbq.size() == 0) begin
               chk("unexpected_credit", 32'(vld), 32'd0);
            end else begin
               int t;
               logic [2:0] e;
               t = sbq.pop_front();
               e = (ret_idx[t] < plan[t].size()) ? plan[t][ret_idx[t]] : 3'bxxx;
               ret_idx[t]++;
               chk("credit_len", 32'(len), 32'(e[1:0]));
               chk("complete_vec", 32'(complete), e[2] ? (32'd1 << t) : 32'd0);
            end
         end else if (complete != '0) begin
            chk("complete_without_credit", 32'(complete), 32'd0);
         end
      end
   end

   task automatic send_b(input logic [7:0] id, input logic [1:0] rsp, output int waited);
      int t;
      waited = 0;
      if (abort) return;
      bvalid = 1'b1;
      bid    = id;
      bresp  = rsp;
      while (!bready && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      if (!bready) begin
         chk("b_accept_timeout", 32'd0, 32'd1);
         bvalid = 1'b0;
         abort  = 1'b1;
         return;
      end
      @(posedge clk);
      t = int'(id[3:0]);
      if (t < NC) begin
         sbq.push_back(t);
         if (rsp != 2'b00 && !exp_berr) begin
            exp_berr = 1'b1;
            exp_bthr = id[3:0];
         end
      end else begin
         exp_err = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic drain(input int limit);
      int n = 0;
      while (sbq.size() != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk("drain_outstanding", 32'(sbq.size()), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, w2;
      // Reset behaviour
      repeat (3) @(negedge clk);
      chk("rst_bready", 32'(bready), 32'd0);
      chk("rst_credit", 32'(vld), 32'd0);
      chk("rst_complete", 32'(complete), 32'd0);
      chk("rst_unknown_err", 32'(err), 32'd0);
      chk("rst_prdy", 32'(prdy), 32'd0);
      rstn = 1'b1;
      @(negedge clk);
      chk("bready_after_reset", 32'(bready), 32'd1);

      // Single response latency on thread 2
      add_cq(2, 3'b111);
      @(negedge clk);
      send_b(8'h02, 2'b00, w);
      bvalid = 1'b0;
      #2;
      chk("lat_prdy_t1", 32'(prdy), 32'b00100);
      @(negedge clk);
      chk("lat_complete_t2", 32'(complete), 32'b00100);
      chk("lat_vld_t2", 32'(vld), 32'd1);
      chk("lat_len_t2", 32'(len), 32'd3);
      @(negedge clk);
      chk("lat_complete_t3", 32'(complete), 32'd0);
      chk("lat_vld_t3", 32'(vld), 32'd0);
      drain(100);

      // Head-of-line stall on empty thread 1 fills the buffer
      send_b(8'h01, 2'b00, w);
      send_b(8'h01, 2'b00, w);
      chk("full_bready_low", 32'(bready), 32'd0);
      fork
         send_b(8'h01, 2'b00, w);
         begin
            repeat (3) @(negedge clk);
            chk("stall_bready_low", 32'(bready), 32'd0);
            chk("stall_no_credit", 32'(vld), 32'd0);
            repeat (3) add_cq(1, 3'b001);
         end
      join
      bvalid = 1'b0;
      drain(100);
      chk("bready_recovers", 32'(bready), 32'd1);

      // Alternating threads 0/4 at full rate
      for (int i = 0; i < 10; i++) begin
         add_cq(0, 3'b100);
         add_cq(4, 3'b100);
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         send_b((i % 2 == 1) ? 8'h04 : 8'h00, 2'b00, w);
         chk("b2b_no_stall", 32'(w), 32'd0);
      end
      bvalid = 1'b0;
      drain(100);
      chk("no_unknown_yet", 32'(err), 32'd0);

      // Unknown thread id
      send_b(8'h0F, 2'b00, w);
      bvalid = 1'b0;
      repeat (3) @(negedge clk);
      chk("unknown_err_set", 32'(err), 32'd1);
      chk("unknown_no_credit", 32'(vld), 32'd0);
      add_cq(0, 3'b101);
      send_b(8'h00, 2'b00, w);
      bvalid = 1'b0;
      drain(100);
      chk("unknown_err_sticky", 32'(err), 32'd1);

`ifdef NVDLA_NOCIF_BRESP_ERR_EN
      add_cq(3, 3'b010);
      add_cq(1, 3'b110);
      send_b(8'h03, 2'b10, w);
      send_b(8'h01, 2'b11, w);
      bvalid = 1'b0;
      drain(100);
      chk("bresp_err_set", 32'(berr), 32'd1);
      chk("bresp_err_thread", 32'(bthr), 32'd3);
`endif

      // Randomized traffic with lagging context queues
      fast = 1'b0;
      for (int i = 0; i < 300 && !abort; i++) begin
         int thr;
         logic [7:0] id;
         thr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, NC - 1));
         id  = {4'($urandom), 4'(thr)};
         if (thr < NC) add_cq(thr, 3'($urandom));
         send_b(id, 2'($urandom), w2);
         if ($urandom_range(0, 3) == 0) begin
            bvalid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
      end
      bvalid = 1'b0;
      fast = 1'b1;
      drain(2000);
      chk("final_unknown_err", 32'(err), 32'(exp_err));
`ifdef NVDLA_NOCIF_BRESP_ERR_EN
      chk("final_bresp_err", 32'(berr), 32'(exp_berr));
      chk("final_bresp_thread", 32'(bthr), 32'(exp_bthr));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
